// File: rtl/riscv_pkg.sv
// Shared register-file geometry and writeback requester indices.
// Also holds the round-robin arbiter's state encoding.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;

    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_LSU = 1'b1
    } last_grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, priority flips after each accepted grant.
//
// state    | meaning
// LAST_ALU | requester 0 won the last handshake, requester 1 wins a tie
// LAST_LSU | requester 1 won the last handshake, requester 0 wins a tie (reset)
module rr_arb2
    import riscv_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    last_grant_e state_q;
    last_grant_e state_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LAST_LSU;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01: grant[WB_ALU] = 1'b1;
            2'b10: grant[WB_LSU] = 1'b1;
            2'b11: begin
                if (state_q == LAST_LSU) begin
                    grant[WB_ALU] = 1'b1;
                end else begin
                    grant[WB_LSU] = 1'b1;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    // Kept apart from the grant decode so advance (derived from grant) forms no loop.
    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = grant[WB_LSU] ? LAST_LSU : LAST_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU and LSU writeback with a registered
// write stage, x0 filtering, read-stage bypass and a saturating conflict counter.
module regfile_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    input  logic [2*ADDR_W-1:0] req_rd,
    input  logic [2*DATA_W-1:0] req_data,
    output logic [1:0]          req_ready,
    output logic                wb_we,
    output logic [ADDR_W-1:0]   wb_rd,
    output logic [DATA_W-1:0]   wb_data,
    input  logic [ADDR_W-1:0]   byp_rs1,
    input  logic [ADDR_W-1:0]   byp_rs2,
    output logic                byp_hit1,
    output logic                byp_hit2,
    output logic [DATA_W-1:0]   byp_data1,
    output logic [DATA_W-1:0]   byp_data2,
    output logic [CNT_W-1:0]    conflict_cnt
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [1:0]        grant;
    logic              handshake;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    assign handshake = |(req_valid & grant);
    assign req_ready = grant;

    rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (req_valid),
        .advance (handshake),
        .grant   (grant)
    );

    always_comb begin
        sel_rd   = req_rd[ADDR_W-1:0];
        sel_data = req_data[DATA_W-1:0];
        if (grant[WB_LSU]) begin
            sel_rd   = req_rd[2*ADDR_W-1:ADDR_W];
            sel_data = req_data[2*DATA_W-1:DATA_W];
        end
    end

    // An x0 destination still completes its handshake but never raises the write enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            wb_we <= handshake && (sel_rd != ZERO_IDX);
            if (handshake) begin
                wb_rd   <= sel_rd;
                wb_data <= sel_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if ((req_valid == 2'b11) && (conflict_cnt != CNT_MAX)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

    assign byp_hit1  = wb_we && (wb_rd == byp_rs1) && (byp_rs1 != ZERO_IDX);
    assign byp_hit2  = wb_we && (wb_rd == byp_rs2) && (byp_rs2 != ZERO_IDX);
    assign byp_data1 = byp_hit1 ? wb_data : '0;
    assign byp_data2 = byp_hit2 ? wb_data : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus reset/saturation sequences.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [9:0]  req_rd = '0;
    logic [63:0] req_data = '0;
    logic [4:0]  byp_rs1 = '0;
    logic [4:0]  byp_rs2 = '0;

    logic [1:0]  req_ready, s_ready;
    logic        wb_we, s_we;
    logic [4:0]  wb_rd, s_rd;
    logic [31:0] wb_data, s_data;
    logic        byp_hit1, byp_hit2, s_hit1, s_hit2;
    logic [31:0] byp_data1, byp_data2, s_bd1, s_bd2;
    logic [15:0] conflict_cnt;
    logic [1:0]  s_cnt;

    int errors = 0;
    int checks = 0;

    logic [31:0] rf [32];
    logic [1:0]  pend;

    always #5 clock = ~clock;

    regfile_wb_arbiter dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_rd(req_rd),
        .req_data(req_data), .req_ready(req_ready), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .byp_rs1(byp_rs1), .byp_rs2(byp_rs2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1),
        .byp_data2(byp_data2), .conflict_cnt(conflict_cnt)
    );

    regfile_wb_arbiter #(.CNT_W(2)) dut_s (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_rd(req_rd),
        .req_data(req_data), .req_ready(s_ready), .wb_we(s_we), .wb_rd(s_rd),
        .wb_data(s_data), .byp_rs1(byp_rs1), .byp_rs2(byp_rs2),
        .byp_hit1(s_hit1), .byp_hit2(s_hit2), .byp_data1(s_bd1),
        .byp_data2(s_bd2), .conflict_cnt(s_cnt)
    );

    // Regfile model; deliberately does not filter x0 so a stray x0 write shows up.
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
    end
    always @(posedge clock) begin
        if (!reset && wb_we) rf[wb_rd] <= wb_data;
    end

    // A pending (valid, not ready) request must stay valid.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pend <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && !req_valid[i]) begin
                    $error("FAIL valid_hold req%0d dropped valid before ready", i);
                end
            end
            pend <= req_valid & ~req_ready;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [4:0]  rd0;
        logic [31:0] d0;
        logic [4:0]  rd1;
        logic [31:0] d1;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  ready;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        hit1;
        logic [31:0] bd1;
        logic        hit2;
        logic [31:0] bd2;
        logic [15:0] cnt;
        logic [1:0]  cnt_s;
    } vec_t;

    vec_t vecs [11];

    initial begin
        //          valid  rd0  d0            rd1  d1            rs1  rs2  ready  we  wrd  wdata         h1  bd1           h2  bd2           cnt  cnt_s
        vecs[0]  = '{2'b01, 5'd1, 32'h12345678, 5'd0, 32'h0,        5'd1, 5'd0, 2'b01, 1, 5'd1, 32'h12345678, 1, 32'h12345678, 0, 32'h0,        16'd0, 2'd0};
        vecs[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd1, 5'd0, 2'b00, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,        16'd0, 2'd0};
        vecs[2]  = '{2'b10, 5'd0, 32'h0,        5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 2'b10, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,        16'd0, 2'd0};
        vecs[3]  = '{2'b11, 5'd2, 32'h87654321, 5'd3, 32'hCAFEF00D, 5'd2, 5'd3, 2'b01, 1, 5'd2, 32'h87654321, 1, 32'h87654321, 0, 32'h0,        16'd1, 2'd1};
        vecs[4]  = '{2'b11, 5'd4, 32'h00000004, 5'd3, 32'hCAFEF00D, 5'd3, 5'd3, 2'b10, 1, 5'd3, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 16'd2, 2'd2};
        vecs[5]  = '{2'b11, 5'd4, 32'h00000004, 5'd5, 32'h55555555, 5'd4, 5'd0, 2'b01, 1, 5'd4, 32'h00000004, 1, 32'h00000004, 0, 32'h0,        16'd3, 2'd3};
        vecs[6]  = '{2'b11, 5'd6, 32'h66666666, 5'd5, 32'h55555555, 5'd0, 5'd5, 2'b10, 1, 5'd5, 32'h55555555, 0, 32'h0,        1, 32'h55555555, 16'd4, 2'd3};
        vecs[7]  = '{2'b11, 5'd6, 32'h66666666, 5'd7, 32'h77777777, 5'd7, 5'd6, 2'b01, 1, 5'd6, 32'h66666666, 0, 32'h0,        1, 32'h66666666, 16'd5, 2'd3};
        vecs[8]  = '{2'b11, 5'd8, 32'h88888888, 5'd7, 32'h77777777, 5'd7, 5'd7, 2'b10, 1, 5'd7, 32'h77777777, 1, 32'h77777777, 1, 32'h77777777, 16'd6, 2'd3};
        vecs[9]  = '{2'b01, 5'd8, 32'h88888888, 5'd0, 32'h0,        5'd8, 5'd0, 2'b01, 1, 5'd8, 32'h88888888, 1, 32'h88888888, 0, 32'h0,        16'd6, 2'd3};
        vecs[10] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        5'd8, 5'd8, 2'b00, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,        16'd6, 2'd3};

        // Reset held 20 ns.
        #20;
        reset = 1'b0;
        #1;
        chk("rst_we", wb_we, 1'b0);
        chk("rst_rd", wb_rd, 5'd0);
        chk("rst_data", wb_data, 32'h0);
        chk("rst_cnt", conflict_cnt, 16'd0);
        chk("rst_ready", req_ready, 2'b00);

        for (int i = 0; i < 11; i++) begin
            req_valid = vecs[i].valid;
            req_rd    = {vecs[i].rd1, vecs[i].rd0};
            req_data  = {vecs[i].d1, vecs[i].d0};
            byp_rs1   = vecs[i].rs1;
            byp_rs2   = vecs[i].rs2;
            #1;
            chk($sformatf("v%0d_ready", i), req_ready, vecs[i].ready);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_we", i), wb_we, vecs[i].we);
            if (vecs[i].we) begin
                chk($sformatf("v%0d_rd", i), wb_rd, vecs[i].wrd);
                chk($sformatf("v%0d_data", i), wb_data, vecs[i].wdata);
            end
            chk($sformatf("v%0d_hit1", i), byp_hit1, vecs[i].hit1);
            chk($sformatf("v%0d_bd1", i), byp_data1, vecs[i].bd1);
            chk($sformatf("v%0d_hit2", i), byp_hit2, vecs[i].hit2);
            chk($sformatf("v%0d_bd2", i), byp_data2, vecs[i].bd2);
            chk($sformatf("v%0d_cnt", i), conflict_cnt, vecs[i].cnt);
            chk($sformatf("v%0d_cnt_sat", i), s_cnt, vecs[i].cnt_s);
        end

        chk("rf_x0", rf[0], 32'h0);
        chk("rf_x1", rf[1], 32'h12345678);
        chk("rf_x2", rf[2], 32'h87654321);
        chk("rf_x3", rf[3], 32'hCAFEF00D);
        chk("rf_x8", rf[8], 32'h88888888);

        // Reset during the write-enable cycle cancels the write.
        req_valid = 2'b10;
        req_rd    = {5'd9, 5'd0};
        req_data  = {32'h99999999, 32'h0};
        #1;
        chk("mid_ready", req_ready, 2'b10);
        @(posedge clock);
        #1;
        chk("mid_we_before", wb_we, 1'b1);
        req_valid = 2'b00;
        reset = 1'b1;
        #1;
        chk("mid_we_cancel", wb_we, 1'b0);
        chk("mid_rd_cancel", wb_rd, 5'd0);
        chk("mid_cnt_clear", conflict_cnt, 16'd0);
        chk("mid_cnt_sat_clear", s_cnt, 2'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("mid_rf_x9", rf[9], 32'h0);

        // Arbiter back in reset state: requester 0 wins the first tie.
        req_valid = 2'b11;
        req_rd    = {5'd11, 5'd10};
        req_data  = {32'hBBBBBBBB, 32'hAAAAAAAA};
        #1;
        chk("post_rst_ready0", req_ready, 2'b01);
        @(posedge clock);
        #1;
        chk("post_rst_rd0", wb_rd, 5'd10);
        chk("post_rst_cnt", conflict_cnt, 16'd1);
        req_valid = 2'b10;
        #1;
        chk("post_rst_ready1", req_ready, 2'b10);
        @(posedge clock);
        #1;
        chk("post_rst_we1", wb_we, 1'b1);
        chk("post_rst_rd1", wb_rd, 5'd11);
        chk("post_rst_data1", wb_data, 32'hBBBBBBBB);
        req_valid = 2'b00;
        @(posedge clock);
        #1;
        chk("post_rst_we_end", wb_we, 1'b0);
        chk("post_rst_rf_x10", rf[10], 32'hAAAAAAAA);
        chk("post_rst_rf_x11", rf[11], 32'hBBBBBBBB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (we/rd/datain) between two writeback requesters: requester 0 is the ALU and requester 1 is the load/store unit. Each requester uses a valid/ready handshake. Arbitration is round-robin, and the granted write is registered before it drives the regfile. A bypass path lets the read stage see the write currently on the port, and a saturating counter records arbitration conflicts.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width (32 registers, x0 hard-wired zero)
CNT_W, 16, width of the saturating conflict counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  2  per-requester write request (bit 0 ALU, bit 1 LSU)
req_rd  in  2*ADDR_W  destination index per requester ([ADDR_W-1:0] is req0)
req_data  in  2*DATA_W  write data per requester
req_ready  out  2  handshake accept per requester, combinational
wb_we  out  1  regfile write enable, registered
wb_rd  out  ADDR_W  regfile write index, registered
wb_data  out  DATA_W  regfile write data, registered
byp_rs1  in  ADDR_W  read-stage source index 1
byp_rs2  in  ADDR_W  read-stage source index 2
byp_hit1  out  1  wb_we && wb_rd==byp_rs1 && byp_rs1!=0
byp_hit2  out  1  same rule for byp_rs2
byp_data1  out  DATA_W  wb_data when byp_hit1, else 0
byp_data2  out  DATA_W  wb_data when byp_hit2, else 0
conflict_cnt  out  CNT_W  count of cycles where both req_valid bits were high

Behaviour:
- Reset values (asynchronous):
  - wb_we=0, wb_rd=0, wb_data=0, conflict_cnt=0.
  - last_grant=1, so requester 0 wins the first conflict.
- Grant logic, combinational from req_valid and last_grant:
  - Exactly one valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted.
  - None valid: no grant.
- req_ready = grant. ready may depend on valid; valid must never depend on ready.
- Requester obligation: hold valid, rd and data stable until ready is seen. Deasserting valid before ready is illegal; the bench asserts on it.
- Handshake completes on the clock edge where valid && ready. At most one handshake occurs per cycle.
- Latency: a handshake at edge t drives wb_we=1 with that rd/data during cycle t..t+1. The regfile commits on edge t+1.
  - wb_we is a single-cycle pulse per handshake.
  - Back-to-back handshakes give continuous wb_we=1.
- rd==0 handshake: accepted normally (ready asserted, last_grant updated) but wb_we stays 0. This is a silent drop; x0 is never written.
- last_grant updates only on a handshake. It is unchanged in idle cycles.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1,... No requester waits more than 1 cycle while the other is valid.
- conflict_cnt:
  - Increments on each edge where req_valid==2'b11.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- Bypass is purely combinational from registered wb_* and byp_rs*. It covers the cycle in which a regfile read would return stale data.
- Reset mid-operation: pending wb_we is cancelled immediately (asynchronous), no regfile write occurs, and the arbiter returns to its reset state. A requester still holding valid after reset deasserts is granted normally.
- No internal queueing. Back-pressure is solely via req_ready.

Decomposition:
- Shared package riscv_pkg: XLEN=32, REG_ADDR_W=5, REG_ZERO=5'd0, and requester index constants WB_ALU=0, WB_LSU=1.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: clock, reset, req[1:0], advance.
  - Output: one-hot grant[1:0].
  - Holds last_grant internally.
- The top module contains the output register stage, the x0 filter, the bypass compare and the counter.

Test Plan:
1. Reset held 20 ns, then released -> wb_we=0, wb_rd=0, wb_data=0, conflict_cnt=0, req_ready=2'b00 with no valid.
2. req0 valid rd=1 data=0x12345678 for one cycle -> req_ready=2'b01; next cycle wb_we=1, wb_rd=1, wb_data=0x12345678; following cycle wb_we=0. Regfile read of x1 returns 0x12345678.
3. Both valid in the same cycle (req0 rd=2 data=0x87654321, req1 rd=3 data=0xCAFEF00D) -> req0 is written first, then req1 on the next cycle; conflict_cnt=1. Both valid held 6 cycles with new data each handshake -> grants alternate 0,1,0,1,0,1.
4. req1 valid rd=0 data=0xFFFFFFFF -> req_ready[1]=1 and handshake completes; wb_we stays 0; regfile x0 still reads 0.
5. Bypass check: after the handshake in scenario 2, during the wb_we cycle set byp_rs1=1 and byp_rs2=0 -> byp_hit1=1, byp_data1=0x12345678, byp_hit2=0, byp_data2=0.
6. Reset asserted in the cycle wb_we=1 -> wb_we drops immediately and the regfile target is unchanged. With CNT_W=2 and 5 dual-valid cycles, conflict_cnt saturates at 3.
